// File: rtl/cache_mesi_arbiter_pkg.sv
// cache_mesi_arbiter_pkg: shared types and helpers for the MESI coherence sequencer.
package cache_mesi_arbiter_pkg;

  localparam int CACHE_MESI_OP_WIDTH = 3;

  typedef enum logic [CACHE_MESI_OP_WIDTH-1:0] {
    CACHE_MESI_OPERATION_REJECT            = 3'd0,
    CACHE_MESI_OPERATION_SHARED            = 3'd1,
    CACHE_MESI_OPERATION_MODIFIED          = 3'd2,
    CACHE_MESI_OPERATION_UPGRADE           = 3'd3,
    CACHE_MESI_OPERATION_NORMAL_EVICT      = 3'd4,
    CACHE_MESI_OPERATION_NORMAL_EVICT_DATA = 3'd5,
    CACHE_MESI_OPERATION_FORCE_EVICT       = 3'd6
  } cache_mesi_operation_t;

  // Requests and responses both carry a plain MESI operation code.
  typedef cache_mesi_operation_t cache_mesi_request_t;
  typedef cache_mesi_operation_t cache_mesi_response_t;

  typedef enum logic [1:0] {
    CACHE_MESI_ARB_IDLE        = 2'd0,
    CACHE_MESI_ARB_SNOOP_ISSUE = 2'd1,
    CACHE_MESI_ARB_SNOOP_WAIT  = 2'd2,
    CACHE_MESI_ARB_RESPOND     = 2'd3
  } cache_mesi_arbiter_state_t;

  // Ownership ops must invalidate every other copy before they are granted.
  function automatic logic cache_is_mesi_ownership_op(cache_mesi_operation_t op);
    return (op == CACHE_MESI_OPERATION_MODIFIED) || (op == CACHE_MESI_OPERATION_UPGRADE);
  endfunction

endpackage

// File: rtl/cache_mesi_arbiter_select.sv
// cache_mesi_arbiter_select: combinational one-hot grant, searching upward from a
// start pointer and wrapping. A pointer of 0 gives lowest-index-first priority.
module cache_mesi_arbiter_select
  import cache_mesi_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2
) (
  input  logic [NUM_CLIENTS-1:0]         req_i,
  input  logic [$clog2(NUM_CLIENTS)-1:0] ptr_i,
  output logic [NUM_CLIENTS-1:0]         grant_o,
  output logic [$clog2(NUM_CLIENTS)-1:0] idx_o,
  output logic                           valid_o
);
  localparam int CLIENT_WIDTH = $clog2(NUM_CLIENTS);

  int                      pos;
  logic [CLIENT_WIDTH-1:0] pos_w;

  // First requester at or after the pointer wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    pos_w   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= NUM_CLIENTS) pos = pos - NUM_CLIENTS;
      pos_w = CLIENT_WIDTH'(pos);
      if (!valid_o && req_i[pos_w]) begin
        valid_o        = 1'b1;
        grant_o[pos_w] = 1'b1;
        idx_o          = pos_w;
      end
    end
  end

endmodule

// File: rtl/cache_mesi_arbiter.sv
// cache_mesi_arbiter: single-transaction MESI coherence sequencer for NUM_CLIENTS
// private caches. Ownership ops snoop every other client and collect acks before
// the response; all other ops respond one cycle after acceptance.
// Optional: define CACHE_MESI_ARBITER_ROUND_ROBIN_EN for round-robin arbitration;
// the default build uses fixed lowest-index priority with no pointer register.
module cache_mesi_arbiter
  import cache_mesi_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 26
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_CLIENTS-1:0]                     req_valid,
  output logic [NUM_CLIENTS-1:0]                     req_ready,
  input  logic [NUM_CLIENTS*CACHE_MESI_OP_WIDTH-1:0] req_op,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]          req_addr,
  output logic [NUM_CLIENTS-1:0]                     resp_valid,
  input  logic [NUM_CLIENTS-1:0]                     resp_ready,
  output logic [CACHE_MESI_OP_WIDTH-1:0]             resp_op,
  output logic [NUM_CLIENTS-1:0]                     snoop_valid,
  input  logic [NUM_CLIENTS-1:0]                     snoop_ready,
  output logic [ADDR_WIDTH-1:0]                      snoop_addr,
  input  logic [NUM_CLIENTS-1:0]                     snoop_ack_valid,
  input  logic [NUM_CLIENTS-1:0]                     snoop_ack_dirty,
  output logic                                       busy,
  output logic                                       dirty_seen
);
  localparam int CLIENT_WIDTH = $clog2(NUM_CLIENTS);

  cache_mesi_arbiter_state_t state_q, state_d;
  logic [CLIENT_WIDTH-1:0]   winner_q, winner_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  cache_mesi_operation_t     resp_op_q, resp_op_d;
  logic [NUM_CLIENTS-1:0]    snoop_pend_q, snoop_pend_d;
  logic [NUM_CLIENTS-1:0]    ack_got_q, ack_got_d;
  logic                      dirty_q, dirty_d;
  logic                      dirty_seen_q, dirty_seen_d;

  logic [NUM_CLIENTS-1:0]    sel_grant;
  logic [CLIENT_WIDTH-1:0]   sel_idx;
  logic                      sel_valid;
  logic [CLIENT_WIDTH-1:0]   ptr;
  cache_mesi_operation_t     sel_op;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [NUM_CLIENTS-1:0]    win_oh;
  logic [NUM_CLIENTS-1:0]    ack_new;

  cache_mesi_arbiter_select #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_select (
    .req_i   (req_valid),
    .ptr_i   (ptr),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

`ifdef CACHE_MESI_ARBITER_ROUND_ROBIN_EN
  logic [CLIENT_WIDTH-1:0] ptr_q, ptr_d;

  // Move the search start just past each accepted winner
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == CACHE_MESI_ARB_IDLE) && sel_valid) begin
      ptr_d = (sel_idx == CLIENT_WIDTH'(NUM_CLIENTS - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Route the selected client's op and line address toward the latches
  always_comb begin
    sel_op   = CACHE_MESI_OPERATION_REJECT;
    sel_addr = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (sel_idx == CLIENT_WIDTH'(i)) begin
        sel_op   = cache_mesi_operation_t'(req_op[i*CACHE_MESI_OP_WIDTH +: CACHE_MESI_OP_WIDTH]);
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign win_oh  = NUM_CLIENTS'(1) << winner_q;
  // Only the first ack from each non-winner counts; own-bit and repeat acks drop out.
  assign ack_new = snoop_ack_valid & ~win_oh & ~ack_got_q;

  // Next-state and handshake outputs for the transaction sequencer
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    addr_d       = addr_q;
    resp_op_d    = resp_op_q;
    snoop_pend_d = snoop_pend_q;
    ack_got_d    = ack_got_q;
    dirty_d      = dirty_q;
    dirty_seen_d = dirty_seen_q;
    req_ready    = '0;
    resp_valid   = '0;

    // Acks are collected while snoops are still being issued as well as while waiting.
    if ((state_q == CACHE_MESI_ARB_SNOOP_ISSUE) || (state_q == CACHE_MESI_ARB_SNOOP_WAIT)) begin
      ack_got_d = ack_got_q | ack_new;
      dirty_d   = dirty_q | (|(ack_new & snoop_ack_dirty));
    end

    case (state_q)
      CACHE_MESI_ARB_IDLE: begin
        req_ready = rst_n ? sel_grant : '0;
        if (sel_valid) begin
          winner_d     = sel_idx;
          addr_d       = sel_addr;
          ack_got_d    = '0;
          dirty_d      = 1'b0;
          snoop_pend_d = '0;
          if (cache_is_mesi_ownership_op(sel_op)) begin
            resp_op_d    = sel_op;
            snoop_pend_d = ~sel_grant;
            state_d      = CACHE_MESI_ARB_SNOOP_ISSUE;
          end else begin
            if ((sel_op == CACHE_MESI_OPERATION_SHARED) ||
                (sel_op == CACHE_MESI_OPERATION_NORMAL_EVICT) ||
                (sel_op == CACHE_MESI_OPERATION_NORMAL_EVICT_DATA)) begin
              resp_op_d = sel_op;
            end else begin
              resp_op_d = CACHE_MESI_OPERATION_REJECT;
            end
            state_d = CACHE_MESI_ARB_RESPOND;
          end
        end
      end
      CACHE_MESI_ARB_SNOOP_ISSUE: begin
        snoop_pend_d = snoop_pend_q & ~snoop_ready;
        if (snoop_pend_d == '0) state_d = CACHE_MESI_ARB_SNOOP_WAIT;
      end
      CACHE_MESI_ARB_SNOOP_WAIT: begin
        if ((ack_got_d | win_oh) == '1) begin
          dirty_seen_d = dirty_d;
          state_d      = CACHE_MESI_ARB_RESPOND;
        end
      end
      CACHE_MESI_ARB_RESPOND: begin
        resp_valid = win_oh;
        if (|(resp_ready & win_oh)) state_d = CACHE_MESI_ARB_IDLE;
      end
      default: state_d = CACHE_MESI_ARB_IDLE;
    endcase
  end

  // Transaction state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CACHE_MESI_ARB_IDLE;
      winner_q     <= '0;
      addr_q       <= '0;
      resp_op_q    <= CACHE_MESI_OPERATION_REJECT;
      snoop_pend_q <= '0;
      ack_got_q    <= '0;
      dirty_q      <= 1'b0;
      dirty_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      addr_q       <= addr_d;
      resp_op_q    <= resp_op_d;
      snoop_pend_q <= snoop_pend_d;
      ack_got_q    <= ack_got_d;
      dirty_q      <= dirty_d;
      dirty_seen_q <= dirty_seen_d;
    end
  end

  assign snoop_valid = snoop_pend_q;
  assign snoop_addr  = addr_q;
  assign resp_op     = resp_op_q;
  assign busy        = (state_q != CACHE_MESI_ARB_IDLE);
  assign dirty_seen  = dirty_seen_q;

endmodule
